// File: rtl/modpow_pkg.sv
// Shared types and constants for the modpow / xorshift unit.
// Macro MODPOW_SKIP_LEADING_ZEROS_EN is consumed by modpow_rng_unit.
package modpow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREP,
    SQR,
    MUL,
    DONE
  } state_t;

  localparam logic [63:0] XS_C = 64'h9E3779B97F4A7C15;

  localparam int XS_SH1 = 13;
  localparam int XS_SH2 = 7;
  localparam int XS_SH3 = 17;

endpackage

// File: rtl/modpow_xorshift.sv
// Free-running xorshift source; state is never zero.
// Seed is taken only while rst is high.
module modpow_xorshift
  import modpow_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed,
  output logic [W-1:0] randn
);

  localparam logic [W-1:0] C = W'(XS_C);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;
  logic [W-1:0] init;

  always_comb begin
    s1 = randn ^ (randn << XS_SH1);
    s2 = s1 ^ (s1 >> XS_SH2);
    s3 = s2 ^ (s2 << XS_SH3);
    init = seed ^ C;
    // a zero state would lock the generator
    if (init == '0) init = C;
  end

  always_ff @(posedge clk) begin
    if (rst) randn <= init;
    else     randn <= s3;
  end

endmodule

// File: rtl/modpow_rng_unit.sv
// Bit-serial x^y mod n engine with a shared interleaved mulmod.
// Define MODPOW_SKIP_LEADING_ZEROS_EN to skip exponent bits above msb(y).
module modpow_rng_unit
  import modpow_pkg::*;
#(
  parameter int mbit = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [mbit:0] seed,
  input  logic [mbit:0] modpow_x,
  input  logic [mbit:0] modpow_y,
  input  logic [mbit:0] modpow_n,
  output logic [mbit:0] modpow_res,
  output logic          modpow_busy,
  output logic [mbit:0] randn
);

  localparam int W  = mbit + 1;
  localparam int CW = $clog2(W);

  state_t state;

  logic [W-1:0]  sx, sy, sn;
  logic [W-1:0]  x, y, n;
  logic [W-1:0]  acc, base, r;
  logic [W:0]    r_nxt;
  logic [W-1:0]  a, b;
  logic [CW-1:0] cnt, ebit, top;
  logic          start;

  modpow_xorshift #(
    .W(W)
  ) u_rng (
    .clk  (clk),
    .rst  (rst),
    .seed (seed),
    .randn(randn)
  );

  assign start = (modpow_x != sx) ||
                 (modpow_y != sy) ||
                 (modpow_n != sn);

`ifdef MODPOW_SKIP_LEADING_ZEROS_EN
  always_comb begin
    top = '0;
    for (int i = 0; i < W; i++)
      if (y[i]) top = CW'(i);
  end
`else
  assign top = CW'(W - 1);
`endif

  // one interleaved shift/add/reduce step per cycle
  always_comb begin
    a = acc;
    b = acc;
    unique case (state)
      PREP:    begin a = W'(1); b = x; end
      MUL:     b = base;
      default: ;
    endcase
    r_nxt = {r, 1'b0};
    if (r_nxt >= {1'b0, n}) r_nxt = r_nxt - {1'b0, n};
    if (b[cnt]) r_nxt = r_nxt + {1'b0, a};
    if (r_nxt >= {1'b0, n}) r_nxt = r_nxt - {1'b0, n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      modpow_busy <= 1'b0;
      modpow_res  <= '0;
      // follow the inputs so reset alone never triggers a job
      sx          <= modpow_x;
      sy          <= modpow_y;
      sn          <= modpow_n;
      x           <= '0;
      y           <= '0;
      n           <= '0;
      acc         <= '0;
      base        <= '0;
      r           <= '0;
      cnt         <= '0;
      ebit        <= '0;
    end else begin
      sx <= modpow_x;
      sy <= modpow_y;
      sn <= modpow_n;
      if (start) begin
        x           <= modpow_x;
        y           <= modpow_y;
        n           <= modpow_n;
        state       <= LOAD;
        modpow_busy <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          LOAD: begin
            cnt <= CW'(W - 1);
            r   <= '0;
            if (n <= W'(1)) begin
              acc   <= '0;
              state <= DONE;
            end else begin
              acc   <= W'(1);
              state <= PREP;
            end
          end
          PREP, SQR, MUL: begin
            r   <= r_nxt[W-1:0];
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              r   <= '0;
              cnt <= CW'(W - 1);
              if (state == PREP) begin
                base  <= r_nxt[W-1:0];
                ebit  <= top;
                state <= SQR;
`ifdef MODPOW_SKIP_LEADING_ZEROS_EN
                if (y == '0) state <= DONE;
`endif
              end else begin
                acc <= r_nxt[W-1:0];
                if (state == SQR && y[ebit]) begin
                  state <= MUL;
                end else if (ebit == '0) begin
                  state <= DONE;
                end else begin
                  ebit  <= ebit - 1'b1;
                  state <= SQR;
                end
              end
            end
          end
          DONE: begin
            modpow_res  <= acc;
            modpow_busy <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modpow_rng_unit.sv
// Randomised self-checking bench for modpow_rng_unit.
// Reference: right-to-left exponentiation with wide % plus an RNG model.
module tb_modpow_rng_unit;

  localparam logic [63:0] C = 64'h9E3779B97F4A7C15;

  logic        clk;
  logic        rst;
  logic [63:0] seed;
  logic [63:0] modpow_x;
  logic [63:0] modpow_y;
  logic [63:0] modpow_n;
  logic [63:0] modpow_res;
  logic        modpow_busy;
  logic [63:0] randn;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rng_m;
  bit          rng_live = 0;
  int          rng_cnt  = 0;
  int          rng_err  = 0;
  int          rng_zero = 0;

  modpow_rng_unit #(
    .mbit(63)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .modpow_x   (modpow_x),
    .modpow_y   (modpow_y),
    .modpow_n   (modpow_n),
    .modpow_res (modpow_res),
    .modpow_busy(modpow_busy),
    .randn      (randn)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xs_step(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  function automatic logic [63:0] xs_init(input logic [63:0] sd);
    logic [63:0] v;
    v = sd ^ C;
    return (v == 0) ? C : v;
  endfunction

  function automatic logic [63:0] ref_pow(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input logic [63:0] n);
    logic [127:0] acc, b, nn;
    if (n <= 1) return 0;
    nn  = {64'd0, n};
    b   = {64'd0, x} % nn;
    acc = 1;
    for (int i = 0; i < 64; i++) begin
      if (y[i]) acc = (acc * b) % nn;
      b = (b * b) % nn;
    end
    return acc[63:0];
  endfunction

  function automatic int exp_len(input logic [63:0] y,
                                 input logic [63:0] n);
    int bits;
    if (n <= 1) return 2;
    bits = 64;
`ifdef MODPOW_SKIP_LEADING_ZEROS_EN
    bits = 0;
    for (int i = 0; i < 64; i++)
      if (y[i]) bits = i + 1;
`endif
    return 2 + 64 + 64 * bits + 64 * $countones(y);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rng_m    <= xs_init(seed);
      rng_live <= 1;
    end else begin
      rng_m <= xs_step(rng_m);
    end
  end

  always @(negedge clk) begin
    if (rng_live) begin
      rng_cnt++;
      if (randn !== rng_m) rng_err++;
      if (randn == 0) rng_zero++;
    end
  end

  task automatic run_job(input string tag,
                         input logic [63:0] x,
                         input logic [63:0] y,
                         input logic [63:0] n,
                         input logic [63:0] exp);
    logic [63:0] old_res;
    int len, chg, lim, el;
    old_res = modpow_res;
    el  = exp_len(y, n);
    lim = el + 16;
    len = 0;
    chg = 0;
    modpow_x = x;
    modpow_y = y;
    modpow_n = n;
    @(negedge clk);
    while (modpow_busy === 1'b1 && len < lim) begin
      if (modpow_res !== old_res) chg++;
      len++;
      @(negedge clk);
    end
    check({tag, "_len"}, 64'(len), 64'(el));
    check({tag, "_hold"}, 64'(chg), 64'd0);
    check({tag, "_res"}, modpow_res, exp);
  endtask

  initial begin
    logic [63:0] rx, ry, rn, sd;
    int busy_seen;

    rst      = 1;
    seed     = 0;
    modpow_x = 0;
    modpow_y = 0;
    modpow_n = 0;
    repeat (2) @(negedge clk);
    check("rst_randn", randn, C);
    check("rst_busy", 64'(modpow_busy), 64'd0);
    check("rst_res", modpow_res, 64'd0);
    rst = 0;
    @(negedge clk);
    check("rng_next", randn, xs_step(C));
    repeat (4) @(negedge clk);
    check("idle_busy", 64'(modpow_busy), 64'd0);

    run_job("p3_5_7", 3, 5, 7, 64'd5);
    run_job("p4_13_497", 4, 13, 497, 64'd445);
    run_job("p10_2_7", 10, 2, 7, 64'd2);
    run_job("y0", 9, 0, 11, 64'd1);
    run_job("n1", 5, 7, 1, 64'd0);
    run_job("n0", 5, 7, 0, 64'd0);

    // first job must be abandoned without publishing 24
    modpow_x = 2;
    modpow_y = 10;
    modpow_n = 1000;
    repeat (300) @(negedge clk);
    check("abort_busy", 64'(modpow_busy), 64'd1);
    run_job("abort", 2, 10, 1023, 64'd1);

    for (int k = 0; k < 3; k++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rn = {$urandom, $urandom} | 64'd2;
      if (k == 1) rn = 64'($urandom_range(2, 5000));
      run_job($sformatf("rand%0d", k), rx, ry, rn, ref_pow(rx, ry, rn));
    end

    modpow_x = 7;
    modpow_y = {$urandom, $urandom};
    modpow_n = 1000003;
    repeat (100) @(negedge clk);
    sd   = {$urandom, $urandom};
    rst  = 1;
    seed = sd;
    @(negedge clk);
    check("mid_rst_busy", 64'(modpow_busy), 64'd0);
    check("mid_rst_res", modpow_res, 64'd0);
    check("mid_rst_randn", randn, xs_init(sd));
    rst = 0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (modpow_busy) busy_seen++;
    end
    check("no_restart", 64'(busy_seen), 64'd0);
    run_job("post_rst", 7, 3, 1000003, ref_pow(7, 3, 1000003));

    check("rng_track", 64'(rng_err), 64'd0);
    check("rng_nonzero", 64'(rng_zero), 64'd0);
    check("rng_active", 64'(rng_cnt > 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
